// File: rtl/dynamic_budget_pkg.sv
// Shared types, default constants and helpers for the dynamic budget tracker.
package dynamic_budget_pkg;

  localparam int unsigned DefOverhead     = 5;
  localparam int unsigned DefPrescalerDiv = 2;

  // Width needed to hold an outstanding count of 0..max_txns.
  function automatic int unsigned count_width(input int unsigned max_txns);
    return $clog2(max_txns + 1);
  endfunction

  // Per-transaction cycle cost: burst beats scaled down to prescaler ticks plus fixed overhead.
  function automatic logic [31:0] cost(input logic [31:0] len,
                                       input int unsigned shift,
                                       input int unsigned overhead);
    return ((len + 32'd1) >> shift) + 32'(overhead);
  endfunction

endpackage

// File: rtl/dynamic_budget_channel.sv
// One channel of the budget tracker: budget accumulator, outstanding counter,
// watchdog timer and sticky timeout/error flags.
// Ports: clk_i/rst_ni clock and async active-low reset; clear_i synchronous clear;
//        tick_i shared prescaler tick; alloc_*/retire_* transaction events;
//        budget_o, outstanding_o, timer_o, timeout_o, err_o registered state.
module dynamic_budget_channel
  import dynamic_budget_pkg::*;
#(
  parameter int unsigned MaxTxns   = 8,
  parameter int unsigned LenWidth  = 8,
  parameter int unsigned AccuWidth = 16,
  parameter int unsigned ShiftAmt  = 1,
  parameter int unsigned Overhead  = DefOverhead,
  parameter int unsigned CntWidth  = count_width(MaxTxns)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 tick_i,
  input  logic                 alloc_valid_i,
  input  logic [LenWidth-1:0]  alloc_len_i,
  input  logic                 retire_valid_i,
  input  logic [LenWidth-1:0]  retire_len_i,
  output logic [AccuWidth-1:0] budget_o,
  output logic [CntWidth-1:0]  outstanding_o,
  output logic [AccuWidth-1:0] timer_o,
  output logic                 timeout_o,
  output logic                 err_o
);

  localparam logic [CntWidth-1:0]  MaxCnt  = CntWidth'(MaxTxns);
  localparam logic [AccuWidth-1:0] AccuMax = '1;

  logic [AccuWidth-1:0] budget_q, budget_d, timer_q, timer_d;
  logic [AccuWidth-1:0] alloc_cost, retire_cost;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic                 timeout_q, timeout_d, err_q, err_d;
  logic                 alloc_ok, retire_ok;
  logic [AccuWidth+1:0] sum;   // two guard bits: MSB flags underflow, next flags overflow
  logic [AccuWidth:0]   tsum;

  assign alloc_cost  = AccuWidth'(cost(32'(alloc_len_i), ShiftAmt, Overhead));
  assign retire_cost = AccuWidth'(cost(32'(retire_len_i), ShiftAmt, Overhead));

  // Acceptance, saturating budget update, counter and watchdog next-state.
  always_comb begin
    retire_ok = retire_valid_i && (cnt_q != '0);
    // A same-cycle retire frees the slot, so a full channel still takes the alloc.
    alloc_ok  = alloc_valid_i && ((cnt_q != MaxCnt) || retire_ok);
    budget_d  = budget_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    timeout_d = timeout_q;
    err_d     = err_q;
    sum  = {2'b00, budget_q}
         + (alloc_ok  ? {2'b00, alloc_cost}  : (AccuWidth+2)'(0))
         - (retire_ok ? {2'b00, retire_cost} : (AccuWidth+2)'(0));
    tsum = {1'b0, timer_q} + {1'b0, alloc_cost};

    if (clear_i) begin
      budget_d  = '0;
      cnt_d     = '0;
      timer_d   = '0;
      timeout_d = 1'b0;
      err_d     = 1'b0;
    end else begin
      if ((alloc_valid_i && !alloc_ok) || (retire_valid_i && !retire_ok)) err_d = 1'b1;

      if (sum[AccuWidth+1]) begin
        budget_d = '0;
        err_d    = 1'b1;
      end else if (sum[AccuWidth]) begin
        budget_d = AccuMax;
        err_d    = 1'b1;
      end else begin
        budget_d = sum[AccuWidth-1:0];
      end

      cnt_d = cnt_q + CntWidth'(alloc_ok) - CntWidth'(retire_ok);

      if (retire_ok) begin
        timer_d = (cnt_d != '0) ? budget_d : '0;
      end else if (alloc_ok) begin
        timer_d = tsum[AccuWidth] ? AccuMax : tsum[AccuWidth-1:0];
      end else if (tick_i && (cnt_q != '0) && (timer_q != '0)) begin
        timer_d = timer_q - AccuWidth'(1);
        if (timer_q == AccuWidth'(1)) timeout_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      budget_q  <= '0;
      cnt_q     <= '0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      budget_q  <= budget_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  assign budget_o      = budget_q;
  assign outstanding_o = cnt_q;
  assign timer_o       = timer_q;
  assign timeout_o     = timeout_q;
  assign err_o         = err_q;

endmodule

// File: rtl/dynamic_budget_tracker.sv
// Multi-channel incremental budget tracker with per-channel prescaled watchdog.
// Ports: clk_i/rst_ni clock and async active-low reset; clear_i synchronous clear;
//        alloc_valid_i/alloc_len_i and retire_valid_i/retire_len_i per-channel events;
//        budget_o, outstanding_o, timer_o, timeout_o, err_o per-channel registered state.
module dynamic_budget_tracker
  import dynamic_budget_pkg::*;
#(
  parameter int unsigned NumChannels  = 2,
  parameter int unsigned MaxTxns      = 8,
  parameter int unsigned LenWidth     = 8,
  parameter int unsigned PrescalerDiv = DefPrescalerDiv,
  parameter int unsigned Overhead     = DefOverhead,
  parameter int unsigned AccuWidth    = 16,
  localparam int unsigned CntWidth    = count_width(MaxTxns)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  clear_i,
  input  logic [NumChannels-1:0]                alloc_valid_i,
  input  logic [NumChannels-1:0][LenWidth-1:0]  alloc_len_i,
  input  logic [NumChannels-1:0]                retire_valid_i,
  input  logic [NumChannels-1:0][LenWidth-1:0]  retire_len_i,
  output logic [NumChannels-1:0][AccuWidth-1:0] budget_o,
  output logic [NumChannels-1:0][CntWidth-1:0]  outstanding_o,
  output logic [NumChannels-1:0][AccuWidth-1:0] timer_o,
  output logic [NumChannels-1:0]                timeout_o,
  output logic [NumChannels-1:0]                err_o
);

  localparam int unsigned ShiftAmt = $clog2(PrescalerDiv);
  localparam int unsigned PsWidth  = (PrescalerDiv > 1) ? $clog2(PrescalerDiv) : 1;

  logic [PsWidth-1:0] ps_q, ps_d;
  logic               tick;

  // Shared free-running prescaler; wraps on the tick.
  always_comb begin
    tick = (ps_q == PsWidth'(PrescalerDiv - 1));
    ps_d = ps_q + PsWidth'(1);
    if (clear_i || tick) ps_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ps_q <= '0;
    else         ps_q <= ps_d;
  end

  for (genvar g = 0; g < NumChannels; g++) begin : g_chan
    dynamic_budget_channel #(
      .MaxTxns   (MaxTxns),
      .LenWidth  (LenWidth),
      .AccuWidth (AccuWidth),
      .ShiftAmt  (ShiftAmt),
      .Overhead  (Overhead),
      .CntWidth  (CntWidth)
    ) u_chan (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .clear_i        (clear_i),
      .tick_i         (tick),
      .alloc_valid_i  (alloc_valid_i[g]),
      .alloc_len_i    (alloc_len_i[g]),
      .retire_valid_i (retire_valid_i[g]),
      .retire_len_i   (retire_len_i[g]),
      .budget_o       (budget_o[g]),
      .outstanding_o  (outstanding_o[g]),
      .timer_o        (timer_o[g]),
      .timeout_o      (timeout_o[g]),
      .err_o          (err_o[g])
    );
  end

endmodule

// File: tb/tb_dynamic_budget_tracker.sv
// Self-checking bench for dynamic_budget_tracker: directed scenarios plus random
// traffic compared every cycle against a behavioural model of the budget rules.
module tb_dynamic_budget_tracker;

  localparam int DIV  = 2;
  localparam int OVH  = 5;
  localparam int MAXT = 8;
  localparam int MAXV = 65535;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic [1:0]        av = '0, rv = '0;
  logic [1:0][7:0]   alen = '0, rlen = '0;
  logic [1:0][15:0]  bud, tmr;
  logic [1:0][3:0]   outs;
  logic [1:0]        tout, err;

  // Narrow-accumulator instance for the saturation case.
  logic [1:0]        a8_v = '0;
  logic [1:0][7:0]   a8_len = '0;
  logic [1:0]        zero2 = '0;
  logic [1:0][7:0]   zero_len = '0;
  logic [1:0][7:0]   b8, t8;
  logic [1:0][3:0]   o8;
  logic [1:0]        to8, e8;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state.
  int m_b[2], m_c[2], m_t[2], m_ps;
  bit m_to[2], m_err[2];

  always #5 clk = ~clk;

  dynamic_budget_tracker dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .alloc_valid_i(av), .alloc_len_i(alen),
    .retire_valid_i(rv), .retire_len_i(rlen),
    .budget_o(bud), .outstanding_o(outs), .timer_o(tmr),
    .timeout_o(tout), .err_o(err)
  );

  dynamic_budget_tracker #(.AccuWidth(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .alloc_valid_i(a8_v), .alloc_len_i(a8_len),
    .retire_valid_i(zero2), .retire_len_i(zero_len),
    .budget_o(b8), .outstanding_o(o8), .timer_o(t8),
    .timeout_o(to8), .err_o(e8)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int tcost(input int len);
    return (len + 1) / DIV + OVH;
  endfunction

  // Model: compare current state, then advance using the inputs the next edge samples.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_ps = 0;
        for (int c = 0; c < 2; c++) begin
          m_b[c] = 0; m_c[c] = 0; m_t[c] = 0; m_to[c] = 0; m_err[c] = 0;
        end
      end
      for (int c = 0; c < 2; c++) begin
        check($sformatf("cyc_budget%0d", c), int'(bud[c]), m_b[c]);
        check($sformatf("cyc_outst%0d", c), int'(outs[c]), m_c[c]);
        check($sformatf("cyc_timer%0d", c), int'(tmr[c]), m_t[c]);
        check($sformatf("cyc_timeout%0d", c), int'(tout[c]), int'(m_to[c]));
        check($sformatf("cyc_err%0d", c), int'(err[c]), int'(m_err[c]));
      end
      if (rst_n) begin
        bit tick;
        tick = (m_ps == DIV - 1);
        m_ps = clear ? 0 : (m_ps + 1) % DIV;
        for (int c = 0; c < 2; c++) begin
          if (clear) begin
            m_b[c] = 0; m_c[c] = 0; m_t[c] = 0; m_to[c] = 0; m_err[c] = 0;
          end else begin
            int ca, cr, nb, nc;
            bit ret_ok, al_ok;
            ca = tcost(int'(alen[c]));
            cr = tcost(int'(rlen[c]));
            ret_ok = rv[c] && m_c[c] > 0;
            al_ok  = av[c] && (m_c[c] < MAXT || ret_ok);
            if ((av[c] && !al_ok) || (rv[c] && !ret_ok)) m_err[c] = 1;
            nb = m_b[c] + (al_ok ? ca : 0) - (ret_ok ? cr : 0);
            if (nb < 0)    begin nb = 0;    m_err[c] = 1; end
            if (nb > MAXV) begin nb = MAXV; m_err[c] = 1; end
            nc = m_c[c] + int'(al_ok) - int'(ret_ok);
            if (ret_ok)      m_t[c] = (nc > 0) ? nb : 0;
            else if (al_ok)  m_t[c] = (m_t[c] + ca > MAXV) ? MAXV : m_t[c] + ca;
            else if (tick && m_c[c] > 0 && m_t[c] > 0) begin
              if (m_t[c] == 1) m_to[c] = 1;
              m_t[c] = m_t[c] - 1;
            end
            m_b[c] = nb;
            m_c[c] = nc;
          end
        end
      end
    end
  end

  // One clock with the given events on channel 0, then return inputs to idle.
  task automatic drive(input logic a, input int al, input logic r, input int rl, input logic clr);
    av[0] = a; alen[0] = 8'(al); rv[0] = r; rlen[0] = 8'(rl); clear = clr;
    @(posedge clk); #1;
    av = '0; rv = '0; alen = '0; rlen = '0; clear = 1'b0;
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_budget", int'(bud[0]), 0);
    check("rst_outst", int'(outs[1]), 0);
    check("rst_err", int'(err), 0);

    // Single alloc then let the watchdog drain.
    drive(1, 7, 0, 0, 0);
    check("a7_budget", int'(bud[0]), 9);
    check("a7_model", m_b[0], 9);
    check("a7_outst", int'(outs[0]), 1);
    check("a7_timer", int'(tmr[0]), 9);
    k = 0;
    while (!tout[0] && k < 40) begin @(posedge clk); #1; k++; end
    check("to_risen", int'(tout[0]), 1);
    check("to_latency_ok", int'(k >= 16 && k <= 19), 1);
    check("to_timer", int'(tmr[0]), 0);
    repeat (3) begin @(posedge clk); #1; end
    check("to_hold_timer", int'(tmr[0]), 0);

    // Clear beats a pending alloc and a set timeout.
    drive(1, 7, 0, 0, 1);
    check("clr_budget", int'(bud[0]), 0);
    check("clr_timeout", int'(tout[0]), 0);
    check("clr_err", int'(err[0]), 0);
    check("clr_outst", int'(outs[0]), 0);

    // Boundary lengths.
    drive(1, 0, 0, 0, 0);   check("a0_budget", int'(bud[0]), 5);
    drive(1, 255, 0, 0, 0); check("a255_budget", int'(bud[0]), 138);
    drive(0, 0, 1, 0, 0);
    check("r0_budget", int'(bud[0]), 133);
    check("r0_timer", int'(tmr[0]), 133);
    check("r0_outst", int'(outs[0]), 1);
    drive(0, 0, 1, 255, 0);
    check("r255_budget", int'(bud[0]), 0);
    check("r255_timer", int'(tmr[0]), 0);
    check("r255_timeout", int'(tout[0]), 0);
    check("r255_err", int'(err[0]), 0);

    // Full channel.
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) drive(1, 3, 0, 0, 0);
    check("full_budget", int'(bud[0]), 56);
    check("full_outst", int'(outs[0]), 8);
    drive(1, 3, 0, 0, 0);
    check("over_err", int'(err[0]), 1);
    check("over_outst", int'(outs[0]), 8);
    check("over_budget", int'(bud[0]), 56);
    drive(1, 3, 1, 3, 0);
    check("swap_outst", int'(outs[0]), 8);
    check("swap_budget", int'(bud[0]), 56);
    check("swap_timer", int'(tmr[0]), 56);
    check("ch1_budget", int'(bud[1]), 0);
    check("ch1_err", int'(err[1]), 0);

    // Retire on empty, then underflow.
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 1, 9, 0);
    check("empty_err", int'(err[0]), 1);
    check("empty_budget", int'(bud[0]), 0);
    check("empty_outst", int'(outs[0]), 0);
    check("empty_ch1_err", int'(err[1]), 0);
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 255, 0);
    check("uflow_budget", int'(bud[0]), 0);
    check("uflow_err", int'(err[0]), 1);
    check("uflow_outst", int'(outs[0]), 0);

    // Saturation on the 8-bit instance.
    a8_v[0] = 1'b1; a8_len[0] = 8'd255;
    repeat (2) begin @(posedge clk); #1; end
    a8_v = '0;
    check("sat_budget", int'(b8[0]), 255);
    check("sat_err", int'(e8[0]), 1);
    check("sat_outst", int'(o8[0]), 2);
    check("sat_timer", int'(t8[0]), 255);

    // Async reset during a countdown.
    drive(0, 0, 0, 0, 1);
    drive(1, 100, 0, 0, 0);
    repeat (4) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("arst_budget", int'(bud[0]), 0);
    check("arst_timer", int'(tmr[0]), 0);
    check("arst_outst", int'(outs[0]), 0);
    check("arst_sat_budget", int'(b8[0]), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Random traffic on both channels.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(299) == 0) begin
        repeat (30) begin @(posedge clk); #1; end
      end
      for (int c = 0; c < 2; c++) begin
        av[c]   = ($urandom_range(99) < 40);
        rv[c]   = ($urandom_range(99) < 35);
        alen[c] = 8'($urandom_range(255));
        rlen[c] = 8'($urandom_range(255));
      end
      clear = ($urandom_range(99) == 0);
      @(posedge clk); #1;
      av = '0; rv = '0; clear = 1'b0;
    end
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
